// File: rtl/wbahb_rr_arbiter_pkg.sv
// wbahb_rr_arbiter_pkg: FSM encoding and limits shared by the WB round-robin arbiter
package wbahb_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_OWN} state_t;
  localparam int MAX_MASTERS = 8;
endpackage

// File: rtl/wbahb_rr_arbiter_picker.sv
// wbahb_rr_arbiter_picker: one-hot round-robin pick of the first requester after last
module wbahb_rr_arbiter_picker #(
  parameter int N = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);
  logic [2*N-1:0] dbl_req, dbl_gnt;
  logic [N-1:0] rot, rot_gnt;
  // rotate so last+1 sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    dbl_req = {req, req} >> (32'(last) + 1);
    rot = dbl_req[N-1:0];
    rot_gnt = rot & (~rot + 1'b1);
    dbl_gnt = {rot_gnt, rot_gnt} << (32'(last) + 1);
    gnt = dbl_gnt[2*N-1:N];
  end
endmodule

// File: rtl/wbahb_rr_arbiter.sv
// wbahb_rr_arbiter: round-robin share of the WB-to-AHB bridge slave port with a stall watchdog
module wbahb_rr_arbiter
  import wbahb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [4*NUM_MASTERS-1:0]      m_sel_i,
  input  logic [AWIDTH*NUM_MASTERS-1:0] m_addr_i,
  input  logic [DWIDTH*NUM_MASTERS-1:0] m_data_i,
  output logic [DWIDTH-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [3:0]                    s_sel_o,
  output logic [AWIDTH-1:0]             s_addr_o,
  output logic [DWIDTH-1:0]             s_data_o,
  input  logic [DWIDTH-1:0]             s_data_i,
  input  logic                          s_ack_i,
  output logic [NUM_MASTERS-1:0]        gnt_o
);
  localparam int LW = $clog2(NUM_MASTERS);
  localparam int WW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_n
    $error("NUM_MASTERS must be 2..8");
  end
  state_t state, state_nx;
  logic [NUM_MASTERS-1:0] pick, gnt_nx;
  logic [LW-1:0] last_owner, last_nx, pick_idx;
  logic [WW-1:0] wdog, wdog_nx;
  logic own_cyc, own_stb, timeout;
  wbahb_rr_arbiter_picker #(.N(NUM_MASTERS), .LW(LW)) u_picker (
    .req(m_cyc_i),
    .last(last_owner),
    .gnt(pick)
  );
  // last_owner is loaded at grant time, so while owning it already names the owner
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= ST_IDLE;
      gnt_o <= '0;
      last_owner <= LW'(NUM_MASTERS - 1);
      wdog <= '0;
    end else begin
      state <= state_nx;
      gnt_o <= gnt_nx;
      last_owner <= last_nx;
      wdog <= wdog_nx;
    end
  always_comb begin
    state_nx = state;
    gnt_nx = gnt_o;
    last_nx = last_owner;
    wdog_nx = '0;
    if (state == ST_IDLE) begin
      state_nx = |m_cyc_i ? ST_OWN : ST_IDLE;
      gnt_nx = |m_cyc_i ? pick : '0;
      last_nx = |m_cyc_i ? pick_idx : last_owner;
    end else if (!own_cyc) begin
      state_nx = ST_IDLE;
      gnt_nx = '0;
    end else
      wdog_nx = (TIMEOUT_CYC != 0 && s_stb_o && !s_ack_i) ? wdog + WW'(1) : '0;
  end
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we_o = 1'b0;
    s_sel_o = '0;
    s_addr_o = '0;
    s_data_o = '0;
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_cyc = own_cyc | (gnt_o[i] & m_cyc_i[i]);
      own_stb = own_stb | (gnt_o[i] & m_stb_i[i]);
      s_we_o = s_we_o | (gnt_o[i] & m_we_i[i]);
      s_sel_o = s_sel_o | (m_sel_i[4*i +: 4] & {4{gnt_o[i]}});
      s_addr_o = s_addr_o | (m_addr_i[AWIDTH*i +: AWIDTH] & {AWIDTH{gnt_o[i]}});
      s_data_o = s_data_o | (m_data_i[DWIDTH*i +: DWIDTH] & {DWIDTH{gnt_o[i]}});
      pick_idx = pick[i] ? LW'(i) : pick_idx;
    end
    // an ack landing on the timeout cycle wins over the error
    timeout = TIMEOUT_CYC != 0 && state == ST_OWN && wdog == WW'(TIMEOUT_CYC) && !s_ack_i;
    s_cyc_o = own_cyc;
    s_stb_o = own_cyc & own_stb & ~timeout;
    m_ack_o = gnt_o & {NUM_MASTERS{s_ack_i}};
    m_err_o = gnt_o & {NUM_MASTERS{timeout}};
    m_data_o = s_data_i;
  end
endmodule

// File: tb/tb_wbahb_rr_arbiter.sv
// tb_wbahb_rr_arbiter: vector table plus scoreboard check of the round-robin arbiter
module tb_wbahb_rr_arbiter;
  typedef struct {
    string name;
    bit rst;
    logic [3:0] cyc, stb, we;
    logic ack;
    logic [3:0] gnt;
    logic scyc, sstb;
    logic [3:0] mack, merr;
  } vec_t;
  logic clk_i, rst_i, s_ack_i;
  logic [3:0] m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, gnt_o, s_sel_o;
  logic [15:0] m_sel_i;
  logic [127:0] m_addr_i, m_data_i;
  logic [31:0] m_data_o, s_addr_o, s_data_o, s_data_i;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] addr_tab [4];
  logic [31:0] data_tab [4];
  logic [3:0] sel_tab [4];
  vec_t tv [$];
  vec_t sb [$];
  int checks, errors;
  wbahb_rr_arbiter #(.NUM_MASTERS(4), .AWIDTH(32), .DWIDTH(32), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  function automatic vec_t mk(input string n, input bit r, input logic [3:0] c, s, w,
                              input logic a, input logic [3:0] g, input logic sc, ss,
                              input logic [3:0] ma, me);
    vec_t v;
    v.name = n; v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.ack = a;
    v.gnt = g; v.scyc = sc; v.sstb = ss; v.mack = ma; v.merr = me;
    return v;
  endfunction
  // each call spans one clock: drive after posedge, check at the following negedge
  task automatic run(input vec_t v);
    vec_t e;
    int k;
    if (v.rst) begin
      rst_i = 1'b1;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
    end
    m_cyc_i = v.cyc; m_stb_i = v.stb; m_we_i = v.we; s_ack_i = v.ack;
    s_data_i = 32'h1234;
    sb.push_back(v);
    #4;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.name, "_gnt"}, 32'(gnt_o), 32'(e.gnt));
      chk({e.name, "_scyc"}, 32'(s_cyc_o), 32'(e.scyc));
      chk({e.name, "_sstb"}, 32'(s_stb_o), 32'(e.sstb));
      chk({e.name, "_mack"}, 32'(m_ack_o), 32'(e.mack));
      chk({e.name, "_merr"}, 32'(m_err_o), 32'(e.merr));
      if (e.mack != 0) chk({e.name, "_mdata"}, m_data_o, 32'h1234);
      if (e.scyc) begin
        k = 0;
        for (int i = 0; i < 4; i++) if (e.gnt[i]) k = i;
        chk({e.name, "_saddr"}, s_addr_o, addr_tab[k]);
        chk({e.name, "_sdata"}, s_data_o, data_tab[k]);
        chk({e.name, "_ssel"}, 32'(s_sel_o), 32'(sel_tab[k]));
        chk({e.name, "_swe"}, 32'(s_we_o), 32'(e.we[k]));
      end
    end
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    checks = 0; errors = 0;
    addr_tab = '{32'h100, 32'h200, 32'h300, 32'hDEAD};
    data_tab = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    sel_tab = '{4'hF, 4'h3, 4'hC, 4'h1};
    for (int i = 0; i < 4; i++) begin
      m_addr_i[32*i +: 32] = addr_tab[i];
      m_data_i[32*i +: 32] = data_tab[i];
      m_sel_i[4*i +: 4] = sel_tab[i];
    end
    rst_i = 1'b1; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; s_ack_i = 1'b0; s_data_i = '0;
    // single master write
    tv.push_back(mk("t1_req", 1, 4'h1, 4'h1, 4'h1, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t1_own", 0, 4'h1, 4'h1, 4'h1, 0, 4'h1, 1, 1, 4'h0, 4'h0));
    tv.push_back(mk("t1_ack", 0, 4'h1, 4'h1, 4'h1, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    tv.push_back(mk("t1_drop", 0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t1_idle", 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    // contention from reset: 0,1,2,3,0 with a dead cycle between owners
    tv.push_back(mk("t2_req", 1, 4'hF, 4'hF, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_g0", 0, 4'hF, 4'hF, 4'h0, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    tv.push_back(mk("t2_d0", 0, 4'hE, 4'hE, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_gap0", 0, 4'hE, 4'hE, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_g1", 0, 4'hE, 4'hE, 4'h0, 1, 4'h2, 1, 1, 4'h2, 4'h0));
    tv.push_back(mk("t2_d1", 0, 4'hC, 4'hC, 4'h0, 0, 4'h2, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_gap1", 0, 4'hC, 4'hC, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_g2", 0, 4'hC, 4'hC, 4'h0, 1, 4'h4, 1, 1, 4'h4, 4'h0));
    tv.push_back(mk("t2_d2", 0, 4'h8, 4'h8, 4'h0, 0, 4'h4, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_gap2", 0, 4'h8, 4'h8, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_g3", 0, 4'h8, 4'h8, 4'h0, 1, 4'h8, 1, 1, 4'h8, 4'h0));
    tv.push_back(mk("t2_d3", 0, 4'h1, 4'h1, 4'h0, 0, 4'h8, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_gap3", 0, 4'h1, 4'h1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t2_g0b", 0, 4'h1, 4'h1, 4'h0, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    tv.push_back(mk("t2_end", 0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    // fairness: m0 re-requests while m2 waits, m2 goes first
    tv.push_back(mk("t3_req0", 0, 4'h1, 4'h1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t3_m0", 0, 4'h5, 4'h5, 4'h0, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    tv.push_back(mk("t3_d0", 0, 4'h4, 4'h4, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t3_rereq", 0, 4'h5, 4'h5, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t3_m2", 0, 4'h5, 4'h5, 4'h0, 1, 4'h4, 1, 1, 4'h4, 4'h0));
    tv.push_back(mk("t3_d2", 0, 4'h1, 4'h1, 4'h0, 0, 4'h4, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t3_gap", 0, 4'h1, 4'h1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t3_m0b", 0, 4'h1, 4'h1, 4'h0, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    tv.push_back(mk("t3_end", 0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    // isolation: m3 drives 0xDEAD with stb/we while m1 owns
    tv.push_back(mk("t4_req1", 0, 4'h2, 4'h2, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t4_m1", 0, 4'hA, 4'hA, 4'h8, 0, 4'h2, 1, 1, 4'h0, 4'h0));
    tv.push_back(mk("t4_ack1", 0, 4'hA, 4'hA, 4'h8, 1, 4'h2, 1, 1, 4'h2, 4'h0));
    tv.push_back(mk("t4_d1", 0, 4'h8, 4'h8, 4'h8, 0, 4'h2, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t4_gap", 0, 4'h8, 4'h8, 4'h8, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t4_m3", 0, 4'h8, 4'h8, 4'h8, 1, 4'h8, 1, 1, 4'h8, 4'h0));
    tv.push_back(mk("t4_end", 0, 4'h0, 4'h0, 4'h0, 0, 4'h8, 0, 0, 4'h0, 4'h0));
    // watchdog at 4 stalled stb cycles, then ack on the timeout cycle suppresses err
    tv.push_back(mk("t5_req", 0, 4'h4, 4'h4, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    for (int i = 1; i <= 4; i++)
      tv.push_back(mk($sformatf("t5_s%0d", i), 0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 1, 4'h0, 4'h0));
    tv.push_back(mk("t5_to", 0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 0, 4'h0, 4'h4));
    for (int i = 1; i <= 4; i++)
      tv.push_back(mk($sformatf("t5_r%0d", i), 0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 1, 4'h0, 4'h0));
    tv.push_back(mk("t5_ackto", 0, 4'h4, 4'h4, 4'h0, 1, 4'h4, 1, 1, 4'h4, 4'h0));
    tv.push_back(mk("t5_after", 0, 4'h4, 4'h4, 4'h0, 0, 4'h4, 1, 1, 4'h0, 4'h0));
    tv.push_back(mk("t5_drop", 0, 4'h0, 4'h0, 4'h0, 0, 4'h4, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t5_end", 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t6_req", 0, 4'h2, 4'h2, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    tv.push_back(mk("t6_own", 0, 4'h2, 4'h2, 4'h0, 0, 4'h2, 1, 1, 4'h0, 4'h0));
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("rst_mack", 32'(m_ack_o), 32'h0);
    chk("rst_merr", 32'(m_err_o), 32'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    foreach (tv[i]) run(tv[i]);
    // async reset while m1 owns with stb high and the bridge acking
    s_ack_i = 1'b1;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_gnt", 32'(gnt_o), 32'h0);
    chk("t6_rst_scyc", 32'(s_cyc_o), 32'h0);
    chk("t6_rst_sstb", 32'(s_stb_o), 32'h0);
    chk("t6_rst_mack", 32'(m_ack_o), 32'h0);
    chk("t6_rst_merr", 32'(m_err_o), 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    s_ack_i = 1'b0;
    run(mk("t6_rel", 0, 4'h3, 4'h3, 4'h0, 0, 4'h0, 0, 0, 4'h0, 4'h0));
    run(mk("t6_m0", 0, 4'h3, 4'h3, 4'h0, 1, 4'h1, 1, 1, 4'h1, 4'h0));
    run(mk("t6_end", 0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 0, 0, 4'h0, 4'h0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
